// File: rtl/edf_index_scheduler_if.sv
// Handshake/config bundle between a requester block and edf_index_scheduler.
// miss_count exists only when DEADLINE_MISS_COUNTER_EN is defined.
interface edf_index_scheduler_if #(
  parameter int unsigned QUEUE_NUMBER   = 7,
  parameter int unsigned DEADLINE_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH    = $clog2(QUEUE_NUMBER)
);
  logic [QUEUE_NUMBER-1:0]   pending;
  logic                      cfg_we;
  logic [INDEX_WIDTH-1:0]    cfg_index;
  logic [DEADLINE_WIDTH-1:0] cfg_period;
  logic                      ready;
  logic                      valid;
  logic [INDEX_WIDTH-1:0]    index;
`ifdef DEADLINE_MISS_COUNTER_EN
  logic [15:0]               miss_count;
`endif

  modport master (
    output pending, cfg_we, cfg_index, cfg_period, ready,
`ifdef DEADLINE_MISS_COUNTER_EN
    input  miss_count,
`endif
    input  valid, index
  );

  modport slave (
    input  pending, cfg_we, cfg_index, cfg_period, ready,
`ifdef DEADLINE_MISS_COUNTER_EN
    output miss_count,
`endif
    output valid, index
  );
endinterface

// File: rtl/edf_index_scheduler.sv
// Earliest-deadline-first index scheduler feeding the MemorEDF selector.
// Optional deadline-miss counter enabled by DEADLINE_MISS_COUNTER_EN.
module edf_index_scheduler #(
  parameter int unsigned QUEUE_NUMBER   = 7,
  parameter int unsigned DEADLINE_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH    = $clog2(QUEUE_NUMBER)
) (
  input  logic                 clock,
  input  logic                 reset,
  edf_index_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSelect, StGrant} state_e;

  localparam logic [INDEX_WIDTH:0] QueueLimit = (INDEX_WIDTH+1)'(QUEUE_NUMBER);

  state_e                    state_q;
  logic                      valid_q;
  logic [INDEX_WIDTH-1:0]    index_q;
  logic [DEADLINE_WIDTH-1:0] period_q   [QUEUE_NUMBER];
  logic [DEADLINE_WIDTH-1:0] deadline_q [QUEUE_NUMBER];
  logic [QUEUE_NUMBER-1:0]   armed_q;

  logic                      handshake;
  logic                      cfg_hit;
  logic                      best_found;
  logic [INDEX_WIDTH-1:0]    best_idx;
  logic [DEADLINE_WIDTH-1:0] best_dl;

  assign handshake = (state_q == StGrant) && bus.ready;
  assign cfg_hit   = bus.cfg_we && ({1'b0, bus.cfg_index} < QueueLimit);

  // Strict '<' while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_dl    = '0;
    for (int i = 0; i < QUEUE_NUMBER; i++) begin
      if (armed_q[i] && (!best_found || deadline_q[i] < best_dl)) begin
        best_found = 1'b1;
        best_idx   = INDEX_WIDTH'(i);
        best_dl    = deadline_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_NUMBER; i++) begin
        period_q[i]   <= '1;
        deadline_q[i] <= '0;
      end
      armed_q <= '0;
    end else begin
      if (cfg_hit) begin
        period_q[bus.cfg_index] <= bus.cfg_period;
      end
      for (int i = 0; i < QUEUE_NUMBER; i++) begin
        if (handshake && index_q == INDEX_WIDTH'(i)) begin
          if (bus.pending[i]) begin
            deadline_q[i] <= period_q[i];
          end else begin
            armed_q[i]    <= 1'b0;
            deadline_q[i] <= '0;
          end
        end else if (!armed_q[i]) begin
          if (bus.pending[i]) begin
            armed_q[i]    <= 1'b1;
            deadline_q[i] <= period_q[i];
          end
        end else if (deadline_q[i] != '0) begin
          deadline_q[i] <= deadline_q[i] - DEADLINE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|armed_q) state_q <= StSelect;
        end
        StSelect: begin
          if (best_found) begin
            index_q <= best_idx;
            valid_q <= 1'b1;
            state_q <= StGrant;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.index = index_q;

`ifdef DEADLINE_MISS_COUNTER_EN
  logic [15:0] miss_q;
  logic [16:0] miss_sum;

  // Only a countdown step from 1 to 0 is a miss; reloads and clears are not.
  always_comb begin
    miss_sum = {1'b0, miss_q};
    for (int i = 0; i < QUEUE_NUMBER; i++) begin
      if (armed_q[i] && deadline_q[i] == DEADLINE_WIDTH'(1) &&
          !(handshake && index_q == INDEX_WIDTH'(i))) begin
        miss_sum = miss_sum + 17'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end

  assign bus.miss_count = miss_q;
`endif

endmodule
